// File: rtl/truth_table_checker_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : truth_table_checker_pkg
//  Brief   : Shared types and constants for the truth-table checker: FSM
//            state encoding, settle-timer width and default expected table.
//  Rev     : 1.0  initial release
// ============================================================================
package truth_table_checker_pkg;

    // Explicit encodings keep state values stable across tools and dumps
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Default table: F = A & B & C, only vector 7 produces a 1
    localparam logic [7:0] c_EXPECTED_AND3 = 8'b1000_0000;

    // Settle counter is wide enough for SETTLE_CYC up to 255
    localparam int c_TIMER_W = 8;

    // State entered when a vector is first applied; a zero settle time
    // skips straight to sampling
    function automatic state_t first_vec_state(input int settle_cyc);
        return (settle_cyc == 0) ? ST_SAMPLE : ST_SETTLE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/truth_table_checker_if.sv
`default_nettype none
// ============================================================================
//  Module  : truth_table_checker_if
//  Brief   : Run-control and DUT-facing signal bundle of the truth-table
//            checker. master = checker side, slave = DUT / controller side.
//            Macro TT_CHECK_ERR_LOG_EN adds the first-failure log signals.
//  Rev     : 1.0  initial release
// ============================================================================
interface truth_table_checker_if #(
    parameter int N_IN = 3
) ();
    logic              start;
    logic              dut_out;
    logic [N_IN-1:0]   dut_in;
    logic              busy;
    logic              done;
    logic              pass;
    logic [N_IN:0]     fail_count;
`ifdef TT_CHECK_ERR_LOG_EN
    logic [N_IN-1:0]   first_fail_vec;
    logic              first_fail_vld;
`endif

    modport master (
        input  start,
        input  dut_out,
        output dut_in,
        output busy,
        output done,
        output pass,
`ifdef TT_CHECK_ERR_LOG_EN
        output first_fail_vec,
        output first_fail_vld,
`endif
        output fail_count
    );

    modport slave (
        output start,
        output dut_out,
        input  dut_in,
        input  busy,
        input  done,
        input  pass,
`ifdef TT_CHECK_ERR_LOG_EN
        input  first_fail_vec,
        input  first_fail_vld,
`endif
        input  fail_count
    );
endinterface
`default_nettype wire

// File: rtl/truth_table_checker_settle_timer.sv
`default_nettype none
// ============================================================================
//  Module  : truth_table_checker_settle_timer
//  Brief   : Per-vector settle counter. clear has priority over enable;
//            expire_o flags the last settle cycle (count == SETTLE_CYC-1).
//  Rev     : 1.0  initial release
// ============================================================================
module truth_table_checker_settle_timer
    import truth_table_checker_pkg::*;
#(
    parameter int SETTLE_CYC = 2
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic clr_i,
    input  wire logic en_i,
    output logic      expire_o
);
    // With a zero settle time the timer is never enabled; the compare value
    // is pinned to 0 only to keep the constant in range
    localparam logic [c_TIMER_W-1:0] c_LAST =
        (SETTLE_CYC > 0) ? c_TIMER_W'(SETTLE_CYC - 1) : '0;

    logic [c_TIMER_W-1:0] cnt_q;
    logic [c_TIMER_W-1:0] cnt_d;

    // Next count: clear wins, otherwise count while enabled
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == c_LAST);

endmodule
`default_nettype wire

// File: rtl/truth_table_checker.sv
`default_nettype none
// ============================================================================
//  Module  : truth_table_checker
//  Brief   : Hardware stimulus/response engine: walks dut_in through every
//            vector 0..2**N_IN-1, holds each for SETTLE_CYC cycles, samples
//            dut_out and counts disagreements with the EXPECTED table.
//            Macro TT_CHECK_ERR_LOG_EN enables first-failure capture.
//  Rev     : 1.0  initial release
// ============================================================================
module truth_table_checker
    import truth_table_checker_pkg::*;
#(
    parameter int                    N_IN       = 3,
    parameter logic [2**N_IN-1:0]    EXPECTED   = c_EXPECTED_AND3,
    parameter int                    SETTLE_CYC = 2
) (
    input  wire logic                clk,
    input  wire logic                reset,
    truth_table_checker_if.master    bus
);
    localparam state_t c_FIRST_ST = first_vec_state(SETTLE_CYC);

    state_t            state_q,  state_d;
    logic [N_IN-1:0]   dut_in_q, dut_in_d;
    logic [N_IN:0]     fail_q,   fail_d;
    logic              busy_q,   busy_d;
    logic              done_q,   done_d;
    logic              pass_q,   pass_d;

    logic              w_start_acc;
    logic              w_mismatch;
    logic [N_IN:0]     w_fail_inc;
    logic              w_tmr_clr;
    logic              w_tmr_en;
    logic              w_expire;

    truth_table_checker_settle_timer #(
        .SETTLE_CYC (SETTLE_CYC)
    ) u_settle_timer (
        .clk      (clk),
        .reset    (reset),
        .clr_i    (w_tmr_clr),
        .en_i     (w_tmr_en),
        .expire_o (w_expire)
    );

    // A run may only be launched from an idle or finished checker
    assign w_start_acc = bus.start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    // Compare response to table; an unknown dut_out falls to the mismatch branch
    always_comb begin
        w_mismatch = 1'b1;
        if (bus.dut_out == EXPECTED[dut_in_q]) begin
            w_mismatch = 1'b0;
        end
    end

    assign w_fail_inc = fail_q + {{N_IN{1'b0}}, w_mismatch};

    // Next-state and datapath control for the run sequencer
    always_comb begin
        state_d   = state_q;
        dut_in_d  = dut_in_q;
        fail_d    = fail_q;
        busy_d    = busy_q;
        done_d    = done_q;
        pass_d    = pass_q;
        w_tmr_clr = 1'b0;
        w_tmr_en  = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (w_start_acc) begin
                    dut_in_d  = '0;
                    fail_d    = '0;
                    done_d    = 1'b0;
                    pass_d    = 1'b0;
                    busy_d    = 1'b1;
                    w_tmr_clr = 1'b1;
                    state_d   = c_FIRST_ST;
                end
            end
            ST_SETTLE: begin
                w_tmr_en = 1'b1;
                if (w_expire) begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                fail_d = w_fail_inc;
                if (&dut_in_q) begin
                    // Last vector: its own result is folded into pass
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (w_fail_inc == '0);
                    state_d = ST_DONE;
                end else begin
                    dut_in_d  = dut_in_q + 1'b1;
                    w_tmr_clr = 1'b1;
                    state_d   = c_FIRST_ST;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer state, vector and result registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            dut_in_q <= '0;
            fail_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            dut_in_q <= dut_in_d;
            fail_q   <= fail_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
        end
    end

    assign bus.dut_in     = dut_in_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.pass       = pass_q;
    assign bus.fail_count = fail_q;

`ifdef TT_CHECK_ERR_LOG_EN
    logic [N_IN-1:0]   ffv_q;
    logic              ffvld_q;

    // Latch the first failing vector of a run; later failures are ignored
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ffv_q   <= '0;
            ffvld_q <= 1'b0;
        end else if (w_start_acc) begin
            ffv_q   <= '0;
            ffvld_q <= 1'b0;
        end else if ((state_q == ST_SAMPLE) && w_mismatch && !ffvld_q) begin
            ffv_q   <= dut_in_q;
            ffvld_q <= 1'b1;
        end
    end

    assign bus.first_fail_vec = ffv_q;
    assign bus.first_fail_vld = ffvld_q;
`endif

endmodule
`default_nettype wire
